// File: rtl/apb_nslv_pkg.sv
// Shared definitions for the APB master bridge: state encoding, default widths
// and the slave-select width helper.
package apb_nslv_pkg;

  localparam int ADDR_W_DEF      = 9;
  localparam int DATA_W_DEF      = 8;
  localparam int NUM_SLV_DEF     = 2;
  localparam int TIMEOUT_CYC_DEF = 64;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = S_IDLE,
    ST_SETUP  = S_SETUP,
    ST_ACCESS = S_ACCESS
  } state_e;

  // A single slave still consumes one address bit so the decode-error path exists.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_master_nslv_if.sv
// Request/response channel plus APB3 fabric signals of the bridge, with the
// bridge-side (master) and fabric-side (slave) views.
interface apb_master_nslv_if #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int NUM_SLV = 2
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [ADDR_W-1:0]         req_addr;
  logic [DATA_W-1:0]         req_wdata;
  logic                      rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic [NUM_SLV-1:0]        PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [ADDR_W-1:0]         PADDR;
  logic [DATA_W-1:0]         PWDATA;
  logic [NUM_SLV-1:0]        PREADY;
  logic [NUM_SLV-1:0]        PSLVERR;
  logic [NUM_SLV*DATA_W-1:0] PRDATA;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PSLVERR, PRDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PSLVERR, PRDATA
  );
endinterface

// File: rtl/apb_addr_decode.sv
// Slave-select decode: top address bits give the slave index, flagged invalid
// when beyond NUM_SLV, and expanded to a one-hot PSEL pattern.
module apb_addr_decode
  import apb_nslv_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_SLV = NUM_SLV_DEF
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic               valid,
  output logic [NUM_SLV-1:0] onehot
);
  localparam int SEL_W = sel_w(NUM_SLV);

  logic [SEL_W-1:0] idx;
  logic             unused_addr_lo;

  assign idx            = addr[ADDR_W-1 -: SEL_W];
  assign unused_addr_lo = ^addr[ADDR_W-SEL_W-1:0];
  assign valid          = (32'(idx) < 32'(NUM_SLV));

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      onehot[i] = valid && (32'(idx) == 32'(i));
    end
  end
endmodule

// File: rtl/apb_master_nslv.sv
// Single-outstanding request/response to APB3 bridge for NUM_SLV slaves.
// Defining APB_TIMEOUT_EN adds an ACCESS-phase timeout of TIMEOUT_CYC cycles.
//
// state     | meaning
// ST_IDLE   | ready for a request; decode errors are answered from here
// ST_SETUP  | PSEL asserted, PENABLE low
// ST_ACCESS | PENABLE high, waiting for the selected slave's PREADY
module apb_master_nslv
  import apb_nslv_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int NUM_SLV     = NUM_SLV_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  apb_master_nslv_if.master  bus
);
  state_e              state_q, state_d;
  logic [NUM_SLV-1:0]  psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                dec_valid;
  logic [NUM_SLV-1:0]  dec_onehot;
  logic                pready_sel, pslverr_sel;
  logic [DATA_W-1:0]   prdata_sel;
`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  apb_addr_decode #(.ADDR_W(ADDR_W), .NUM_SLV(NUM_SLV)) u_dec (
    .addr   (bus.req_addr),
    .valid  (dec_valid),
    .onehot (dec_onehot)
  );

  // PSEL is one-hot while a transfer is live, so it doubles as the response mux select.
  assign pready_sel  = |(bus.PREADY & psel_q);
  assign pslverr_sel = |(bus.PSLVERR & psel_q);

  always_comb begin
    prdata_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (psel_q[i]) prdata_sel = prdata_sel | bus.PRDATA[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
`ifdef APB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          pwrite_d = bus.req_write;
          paddr_d  = bus.req_addr;
          pwdata_d = bus.req_wdata;
          if (dec_valid) begin
            state_d = ST_SETUP;
            psel_d  = dec_onehot;
`ifdef APB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (pready_sel) begin
          state_d     = ST_IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr_sel;
          rsp_rdata_d = pwrite_q ? '0 : prdata_sel;
        end
`ifdef APB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d     = ST_IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE) && PRESETn;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
endmodule

// File: tb/tb_apb_master_nslv.sv
// Bench for apb_master_nslv (3 slaves, 9-bit address): directed and random
// transfers checked every cycle against a transaction-schedule model.
module tb_apb_master_nslv;
  localparam int AW = 9;
  localparam int DW = 8;
  localparam int NS = 3;
  localparam int TO = 8;
`ifdef APB_TIMEOUT_EN
  localparam int LIM = TO - 1;
`else
  localparam int LIM = 1 << 30;
`endif

  logic PCLK = 1'b0;
  logic PRESETn;
  always #5 PCLK = ~PCLK;

  apb_master_nslv_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS)) bus();

  apb_master_nslv #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .TIMEOUT_CYC(TO)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus.master)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model of the one live transfer: PSEL over [m_s, m_e], PENABLE over [m_s+1, m_e],
  // the selected PREADY rises at m_rdy_at, the response appears at rsp_at.
  bit          m_act;
  int          m_s, m_e, m_rdy_at, m_idx;
  bit          m_se;
  logic [7:0]  m_rd;
  int          rsp_at;
  bit          rsp_err_e;
  logic [7:0]  rsp_rd_e;
  logic [8:0]  l_addr;
  logic [7:0]  l_wdata;
  bit          l_write;

  logic [2:0]  lg_psel [0:63];
  bit          lg_pen  [0:63];
  bit          lg_rv   [0:63];
  bit          lg_err  [0:63];
  bit          lg_rr   [0:63];
  logic [7:0]  lg_rd   [0:63];
  logic [8:0]  lg_addr [0:63];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_act   = 1'b0;
    rsp_at  = -1;
    l_addr  = '0;
    l_wdata = '0;
    l_write = 1'b0;
  endtask

  task automatic step(input bit rv, input bit wr, input logic [8:0] a, input logic [7:0] wd,
                      input int w, input bit se, input logic [7:0] rd);
    logic [2:0]  e_psel, rdy, err;
    logic [23:0] prd;
    bit          e_rr, e_pen, busy;
    int          idx;
    @(negedge PCLK);
    busy   = m_act && cyc >= m_s && cyc <= m_e;
    e_rr   = !busy;
    e_psel = busy ? 3'(1 << m_idx) : 3'b000;
    e_pen  = m_act && cyc >= m_s + 1 && cyc <= m_e;
    check("req_ready", 32'(bus.req_ready), 32'(e_rr));
    check("psel",      32'(bus.PSEL),      32'(e_psel));
    check("penable",   32'(bus.PENABLE),   32'(e_pen));
    check("paddr",     32'(bus.PADDR),     32'(l_addr));
    check("pwdata",    32'(bus.PWDATA),    32'(l_wdata));
    check("pwrite",    32'(bus.PWRITE),    32'(l_write));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(cyc == rsp_at));
    if (cyc == rsp_at) begin
      check("rsp_err",   32'(bus.rsp_err),   32'(rsp_err_e));
      check("rsp_rdata", 32'(bus.rsp_rdata), 32'(rsp_rd_e));
    end
    if (cyc < 64) begin
      lg_psel[cyc] = bus.PSEL;
      lg_pen[cyc]  = bus.PENABLE;
      lg_rv[cyc]   = bus.rsp_valid;
      lg_err[cyc]  = bus.rsp_err;
      lg_rr[cyc]   = bus.req_ready;
      lg_rd[cyc]   = bus.rsp_rdata;
      lg_addr[cyc] = bus.PADDR;
    end
    // Unselected slaves and the SETUP cycle see random noise.
    rdy = 3'($urandom);
    err = 3'($urandom);
    prd = 24'($urandom);
    if (e_pen) begin
      rdy[m_idx] = (cyc == m_rdy_at);
      if (cyc == m_rdy_at) begin
        err[m_idx]          = m_se;
        prd[m_idx*8 +: 8]   = m_rd;
      end
    end
    bus.PREADY    = rdy;
    bus.PSLVERR   = err;
    bus.PRDATA    = prd;
    bus.req_valid = rv;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    if (rv && e_rr) begin
      l_addr  = a;
      l_wdata = wd;
      l_write = wr;
      idx     = int'(a[8:7]);
      if (idx >= NS) begin
        m_act     = 1'b0;
        rsp_at    = cyc + 1;
        rsp_err_e = 1'b1;
        rsp_rd_e  = 8'h00;
      end else begin
        m_act = 1'b1;
        m_idx = idx;
        m_s   = cyc + 1;
        m_se  = se;
        m_rd  = rd;
        if (w > LIM) begin
          m_e       = cyc + 2 + LIM;
          m_rdy_at  = -1;
          rsp_err_e = 1'b1;
          rsp_rd_e  = 8'h00;
        end else begin
          m_e       = cyc + 2 + w;
          m_rdy_at  = m_e;
          rsp_err_e = se;
          rsp_rd_e  = wr ? 8'h00 : rd;
        end
        rsp_at = m_e + 1;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 9'h000, 8'h00, 0, 1'b0, 8'h00);
  endtask

  initial begin
    PRESETn       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.PREADY    = '0;
    bus.PSLVERR   = '0;
    bus.PRDATA    = '0;
    model_reset();
    #12;
    check("rst_psel",      32'(bus.PSEL),      32'h0);
    check("rst_penable",   32'(bus.PENABLE),   32'h0);
    check("rst_pwrite",    32'(bus.PWRITE),    32'h0);
    check("rst_paddr",     32'(bus.PADDR),     32'h0);
    check("rst_pwdata",    32'(bus.PWDATA),    32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rsp_err",   32'(bus.rsp_err),   32'h0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'h0);
    check("rst_req_ready", 32'(bus.req_ready), 32'h0);
    @(negedge PCLK);
    PRESETn = 1'b1;

    // Directed: write slave 0, read slave 1 with 3 waits, decode error,
    // PSLVERR write, then a read accepted on the response cycle.
    step(1'b1, 1'b1, 9'h005, 8'hA5, 0, 1'b0, 8'h00);
    idle(2);
    step(1'b1, 1'b0, 9'h0F0, 8'h00, 3, 1'b0, 8'h3C);
    idle(5);
    step(1'b1, 1'b0, 9'h1C0, 8'h00, 0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 9'h010, 8'h77, 1, 1'b1, 8'h00);
    idle(3);
    step(1'b1, 1'b0, 9'h080, 8'h00, 0, 1'b0, 8'h11);
    idle(3);

    check("lit_psel_c1",  32'(lg_psel[1]), 32'h1);
    check("lit_psel_c2",  32'(lg_psel[2]), 32'h1);
    check("lit_pen_c1",   32'(lg_pen[1]),  32'h0);
    check("lit_pen_c2",   32'(lg_pen[2]),  32'h1);
    check("lit_psel_c3",  32'(lg_psel[3]), 32'h0);
    check("lit_rv_c3",    32'(lg_rv[3]),   32'h1);
    check("lit_err_c3",   32'(lg_err[3]),  32'h0);
    check("lit_psel_c4",  32'(lg_psel[4]), 32'h2);
    check("lit_pen_c5",   32'(lg_pen[5]),  32'h1);
    check("lit_pen_c8",   32'(lg_pen[8]),  32'h1);
    check("lit_paddr_c8", 32'(lg_addr[8]), 32'h0F0);
    check("lit_rv_c8",    32'(lg_rv[8]),   32'h0);
    check("lit_rv_c9",    32'(lg_rv[9]),   32'h1);
    check("lit_rd_c9",    32'(lg_rd[9]),   32'h3C);
    check("lit_psel_c10", 32'(lg_psel[10]), 32'h0);
    check("lit_rv_c10",   32'(lg_rv[10]),  32'h1);
    check("lit_err_c10",  32'(lg_err[10]), 32'h1);
    check("lit_rd_c10",   32'(lg_rd[10]),  32'h0);
    check("lit_rv_c14",   32'(lg_rv[14]),  32'h1);
    check("lit_err_c14",  32'(lg_err[14]), 32'h1);
    check("lit_rr_c14",   32'(lg_rr[14]),  32'h1);
    check("lit_psel_c15", 32'(lg_psel[15]), 32'h2);
    check("lit_rv_c17",   32'(lg_rv[17]),  32'h1);
    check("lit_rd_c17",   32'(lg_rd[17]),  32'h11);

    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 9) < 7), 1'($urandom), 9'($urandom), 8'($urandom),
           ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 1)),
           1'($urandom), 8'($urandom));
    end
    idle(15);

    // Reset in the middle of a long ACCESS phase.
    step(1'b1, 1'b0, 9'h005, 8'h00, 20, 1'b0, 8'h5A);
    idle(3);
    #1 PRESETn = 1'b0;
    #1;
    check("arst_psel",      32'(bus.PSEL),      32'h0);
    check("arst_penable",   32'(bus.PENABLE),   32'h0);
    check("arst_req_ready", 32'(bus.req_ready), 32'h0);
    check("arst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    model_reset();
    bus.req_valid = 1'b0;
    bus.PREADY    = '0;
    @(posedge PCLK);
    @(posedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    idle(30);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
